instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle control FSM that sequences the 4-bit program counter, the instruction fetch, the data-memory load and the register-file writeback in the small CPU.
- Fetches a 10-bit instruction over a req/ack handshake and latches it into an internal IR.
- Decodes the IR and drives the PC control lines (PL, JB, BC, LADDR, RADDR) for exactly one qualified cycle per instruction.
- The PC samples its controls only in cycles where PC_EN=1.

Parameters:
- ACK_TIMEOUT, 15: max consecutive cycles a wait state holds REQ without ACK before FAULT; legal range 1..2^TMO_W-1.
- TMO_W, 4: width of the timeout counter.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  asynchronous active-high reset.
- RUN  in  1  start/continue request; sampled in IDLE and EXEC only.
- INSTR  in  10  instruction word from instruction memory; valid when IM_ACK=1.
- IM_ACK  in  1  instruction memory acknowledge.
- DM_ACK  in  1  data memory acknowledge.
- IM_REQ  out  1  instruction fetch request.
- DM_REQ  out  1  data load request.
- RF_WE  out  1  register-file write enable, one cycle.
- PC_EN  out  1  PC update qualifier.
- PL  out  1  PC load select (0 = increment).
- JB  out  1  PC jump select.
- BC  out  1  PC branch condition select (0 = zero, 1 = negative).
- LADDR  out  2  branch offset high bits, IR[3:2].
- RADDR  out  2  branch offset low bits, IR[1:0].
- STATE  out  3  current state encoding.
- HALTED  out  1  1 in HALT or FAULT.
- FAULT  out  1  1 in FAULT.
- ILLEGAL  out  1  sticky: an undefined opcode was decoded.

Behaviour:
- Reset (async, immediate): state=IDLE, IR=0, timeout counter=0, ILLEGAL=0. All outputs 0. Reset mid-handshake drops REQ in the same instant.
- Outputs are Moore functions of state and IR (no input-to-output combinational paths).
- LADDR=IR[3:2] and RADDR=IR[1:0] at all times.
- Opcode = IR[9:6]:
  - 0000 NOP
  - 0001 ALU
  - 0010 LOAD
  - 0011 JMP
  - 0100 BRZ
  - 0101 BRN
  - 1111 HALT
  - others are illegal and execute as NOP.
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEM=3, WB=4, EXEC=5, HALT=6, FAULT=7.
- IDLE: RUN=1 -> FETCH; otherwise stay.
- FETCH: IM_REQ=1.
  - IM_ACK=1 -> IR<=INSTR, go to DECODE.
  - Else the counter increments. If ACK_TIMEOUT consecutive FETCH cycles pass without ack -> FAULT.
  - An ack in the ACK_TIMEOUT-th cycle is accepted.
  - The counter clears on every entry to FETCH or MEM.
- DECODE (1 cycle), next state by opcode:
  - HALT -> HALT (PC not advanced)
  - ALU -> WB
  - LOAD -> MEM
  - all others -> EXEC
  - An illegal opcode sets ILLEGAL (sticky until RST).
- MEM: DM_REQ=1. DM_ACK=1 -> WB. Timeout rule identical to FETCH -> FAULT.
- WB: RF_WE=1 for exactly one cycle -> EXEC.
- EXEC: PC_EN=1 for exactly one cycle. PC controls by opcode:
  - NOP/ALU/LOAD/illegal: PL=0, JB=0, BC=0
  - JMP: PL=1, JB=1, BC=0
  - BRZ: PL=1, JB=0, BC=0
  - BRN: PL=1, JB=0, BC=1
  - Next state: RUN=1 -> FETCH; RUN=0 -> IDLE (pause; resuming fetches the next instruction).
- Outside EXEC: PC_EN=0, PL=0, JB=0, BC=0.
- HALT: HALTED=1; terminal until RST. RUN is ignored.
- FAULT: HALTED=1, FAULT=1; terminal until RST. REQ outputs are 0.
- Per-instruction latency from FETCH entry, assuming ack on the first cycle:
  - NOP/JMP/BR: 3 cycles
  - ALU: 4 cycles
  - LOAD: 5 cycles
  - Each ack wait cycle adds 1.
- ACK outside the matching wait state is ignored.
- IR changes only on an accepted IM_ACK.

Test Plan:
- Reset, RUN=1, INSTR=0000_00_00_00 with IM_ACK on the first FETCH cycle: STATE goes 0->1->2->5->1. PC_EN=1 with PL=0 in the EXEC cycle only.
- INSTR=0011_00_10_11 (JMP): EXEC shows PL=1, JB=1, BC=0, LADDR=2'b10, RADDR=2'b11, PC_EN=1 for 1 cycle.
- INSTR=0010_xx (LOAD) with DM_ACK delayed 3 cycles: DM_REQ high for 4 cycles. RF_WE pulses 1 cycle, then EXEC (PL=0). Total 8 cycles from FETCH entry to the next FETCH.
- INSTR=0101_00_01_10 (BRN): EXEC PL=1, JB=0, BC=1. Then opcode 1001: ILLEGAL=1, executes as increment. Opcode 1111: STATE=6, HALTED=1, stays there with RUN=1.
- IM_ACK withheld, ACK_TIMEOUT=15: IM_REQ high for 15 cycles, then STATE=7, FAULT=1, IM_REQ=0. A second run with the ack in cycle 15 is accepted with no FAULT.
- RST asserted mid-MEM with DM_REQ=1: DM_REQ, STATE, ILLEGAL and IR clear immediately, without waiting for a clock edge. RUN=0 during EXEC -> IDLE; RUN=1 resumes FETCH.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control FSM for the small CPU.
// Sequences fetch, decode, data load, writeback and the single qualified PC update.
module instr_sequencer #(
    parameter int ACK_TIMEOUT = 15,
    parameter int TMO_W = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RUN,
    input  logic [9:0] INSTR,
    input  logic       IM_ACK,
    input  logic       DM_ACK,
    output logic       IM_REQ,
    output logic       DM_REQ,
    output logic       RF_WE,
    output logic       PC_EN,
    output logic       PL,
    output logic       JB,
    output logic       BC,
    output logic [1:0] LADDR,
    output logic [1:0] RADDR,
    output logic [2:0] STATE,
    output logic       HALTED,
    output logic       FAULT,
    output logic       ILLEGAL
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM, S_WB, S_EXEC, S_HALT, S_FAULT
    } state_t;
    localparam logic [3:0] OP_ALU = 4'h1, OP_LOAD = 4'h2, OP_JMP = 4'h3;
    localparam logic [3:0] OP_BRZ = 4'h4, OP_BRN = 4'h5, OP_HALT = 4'hF;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    state_t state, nxt;
    logic [9:0] ir;
    logic [TMO_W-1:0] cnt;
    logic [3:0] op;
    logic timed_out;
    assign op = ir[9:6];
    assign timed_out = cnt == TMO_LAST;
    assign STATE = state;
    assign LADDR = ir[3:2];
    assign RADDR = ir[1:0];
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   nxt = RUN ? S_FETCH : S_IDLE;
            S_FETCH:  nxt = IM_ACK ? S_DECODE : timed_out ? S_FAULT : S_FETCH;
            S_DECODE: nxt = op == OP_HALT ? S_HALT : op == OP_ALU ? S_WB : op == OP_LOAD ? S_MEM : S_EXEC;
            S_MEM:    nxt = DM_ACK ? S_WB : timed_out ? S_FAULT : S_MEM;
            S_WB:     nxt = S_EXEC;
            S_EXEC:   nxt = RUN ? S_FETCH : S_IDLE;
            default:  nxt = state;
        endcase
    end
    // Outputs are registered from the next state so they are pure Moore signals.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            ir <= '0;
            cnt <= '0;
            ILLEGAL <= 1'b0;
            {IM_REQ, DM_REQ, RF_WE, PC_EN, PL, JB, BC, HALTED, FAULT} <= '0;
        end else begin
            state <= nxt;
            if (state == S_FETCH && IM_ACK) ir <= INSTR;
            cnt <= (state == nxt && (state == S_FETCH || state == S_MEM)) ? cnt + 1'b1 : '0;
            if (state == S_DECODE && op > OP_BRN && op != OP_HALT) ILLEGAL <= 1'b1;
            IM_REQ <= nxt == S_FETCH;
            DM_REQ <= nxt == S_MEM;
            RF_WE <= nxt == S_WB;
            PC_EN <= nxt == S_EXEC;
            PL <= nxt == S_EXEC && (op == OP_JMP || op == OP_BRZ || op == OP_BRN);
            JB <= nxt == S_EXEC && op == OP_JMP;
            BC <= nxt == S_EXEC && op == OP_BRN;
            HALTED <= nxt == S_HALT || nxt == S_FAULT;
            FAULT <= nxt == S_FAULT;
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized instruction stream checked against per-instruction
// state traces derived from the latency and output rules of the sequencer.
module tb_instr_sequencer;
    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, MEM = 3'd3;
    localparam logic [2:0] WB = 3'd4, EXEC = 3'd5, HALT = 3'd6, FLT = 3'd7;
    logic CLK = 1'b0, RST = 1'b0, RUN = 1'b0, IM_ACK = 1'b0, DM_ACK = 1'b0;
    logic [9:0] INSTR = '0;
    logic IM_REQ, DM_REQ, RF_WE, PC_EN, PL, JB, BC, HALTED, FAULT, ILLEGAL;
    logic [1:0] LADDR, RADDR;
    logic [2:0] STATE;
    int n_chk = 0, n_fail = 0;
    logic [9:0] m_ir = '0;
    logic m_ill = 1'b0;

    instr_sequencer #(.ACK_TIMEOUT(15), .TMO_W(4)) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .INSTR(INSTR), .IM_ACK(IM_ACK), .DM_ACK(DM_ACK),
        .IM_REQ(IM_REQ), .DM_REQ(DM_REQ), .RF_WE(RF_WE), .PC_EN(PC_EN), .PL(PL), .JB(JB),
        .BC(BC), .LADDR(LADDR), .RADDR(RADDR), .STATE(STATE), .HALTED(HALTED),
        .FAULT(FAULT), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    function automatic logic [16:0] obs();
        return {STATE, IM_REQ, DM_REQ, RF_WE, PC_EN, PL, JB, BC, LADDR, RADDR, HALTED, FAULT, ILLEGAL};
    endfunction

    // Expected outputs for a state, using the model's IR and sticky illegal flag.
    function automatic logic [16:0] expect_vec(input logic [2:0] st);
        logic [3:0] op;
        logic ex;
        op = m_ir[9:6];
        ex = st == EXEC;
        return {st, st == FETCH, st == MEM, st == WB, ex, ex && op inside {4'h3, 4'h4, 4'h5},
                ex && op == 4'h3, ex && op == 4'h5, m_ir[3:0], st >= HALT, st == FLT, m_ill};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        RUN = 1'b0;
        IM_ACK = 1'b0;
        DM_ACK = 1'b0;
        tick();
        RST = 1'b0;
        m_ir = '0;
        m_ill = 1'b0;
    endtask

    task automatic test_reset();
        #2 RST = 1'b1;
        #1;
        n_chk++;
        if (obs() !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", obs(), 17'd0);
        end
        tick();
        RST = 1'b0;
        tick();
        n_chk++;
        if (obs() !== expect_vec(IDLE)) begin
            n_fail++;
            $display("FAIL reset_idle: got %h expected %h", obs(), expect_vec(IDLE));
        end
    endtask

    task automatic test_program();
        logic [9:0] dir [5] = '{10'b0000_00_00_00, 10'b0011_00_10_11, 10'b0010_01_10_01,
                                10'b0101_00_01_10, 10'b1001_00_11_00};
        logic [9:0] prog[$];
        logic [2:0] tr[$];
        logic [9:0] ins;
        logic [3:0] op;
        int iw, dw;
        foreach (dir[i]) prog.push_back(dir[i]);
        repeat (24) begin
            ins = 10'($urandom);
            ins[9:6] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 14)) : 4'($urandom_range(0, 7));
            prog.push_back(ins);
        end
        prog.push_back(10'b1111_00_11_01);
        RUN = 1'b1;
        IM_ACK = 1'b0;
        n_chk++;
        if (obs() !== expect_vec(IDLE)) begin
            n_fail++;
            $display("FAIL program_start: got %h expected %h", obs(), expect_vec(IDLE));
        end
        tick();
        foreach (prog[k]) begin
            ins = prog[k];
            op = ins[9:6];
            iw = k == 0 ? 0 : $urandom_range(0, 3);
            dw = k == 2 ? 3 : $urandom_range(0, 4);
            tr.delete();
            repeat (iw + 1) tr.push_back(FETCH);
            tr.push_back(DECODE);
            if (op == 4'h2) repeat (dw + 1) tr.push_back(MEM);
            if (op == 4'h1 || op == 4'h2) tr.push_back(WB);
            if (op == 4'hF) repeat (4) tr.push_back(HALT);
            else tr.push_back(EXEC);
            foreach (tr[j]) begin
                if (tr[j] == DECODE) m_ir = ins;
                n_chk++;
                if (obs() !== expect_vec(tr[j])) begin
                    n_fail++;
                    $display("FAIL program instr %0d (%h) cycle %0d: got %h expected %h",
                             k, ins, j, obs(), expect_vec(tr[j]));
                end
                if (tr[j] == DECODE && !(op <= 4'h5 || op == 4'hF)) m_ill = 1'b1;
                RUN = tr[j] inside {EXEC, HALT} ? 1'b1 : 1'($urandom);
                IM_ACK = tr[j] == FETCH ? j == iw : 1'($urandom);
                INSTR = (tr[j] == FETCH && j == iw) ? ins : 10'($urandom);
                DM_ACK = tr[j] == MEM ? j == iw + 2 + dw : 1'($urandom);
                tick();
            end
        end
        IM_ACK = 1'b0;
        DM_ACK = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        RUN = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) begin
            n_chk++;
            if (obs() !== expect_vec(FETCH)) begin
                n_fail++;
                $display("FAIL fetch_wait cycle %0d: got %h expected %h", i, obs(), expect_vec(FETCH));
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (obs() !== expect_vec(FLT)) begin
                n_fail++;
                $display("FAIL fetch_fault cycle %0d: got %h expected %h", i, obs(), expect_vec(FLT));
            end
            RUN = 1'($urandom);
            IM_ACK = 1'b1;
            tick();
        end
        do_reset();
        RUN = 1'b1;
        INSTR = 10'b0010_00_01_11;
        tick();
        for (int i = 0; i < 15; i++) begin
            n_chk++;
            if (obs() !== expect_vec(FETCH)) begin
                n_fail++;
                $display("FAIL fetch_late_ack cycle %0d: got %h expected %h", i, obs(), expect_vec(FETCH));
            end
            IM_ACK = i == 14;
            tick();
        end
        IM_ACK = 1'b0;
        m_ir = INSTR;
        n_chk++;
        if (obs() !== expect_vec(DECODE)) begin
            n_fail++;
            $display("FAIL late_ack_accepted: got %h expected %h", obs(), expect_vec(DECODE));
        end
        tick();
        for (int i = 0; i < 15; i++) begin
            n_chk++;
            if (obs() !== expect_vec(MEM)) begin
                n_fail++;
                $display("FAIL mem_wait cycle %0d: got %h expected %h", i, obs(), expect_vec(MEM));
            end
            tick();
        end
        n_chk++;
        if (obs() !== expect_vec(FLT)) begin
            n_fail++;
            $display("FAIL mem_fault: got %h expected %h", obs(), expect_vec(FLT));
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [9:0] seq [2] = '{10'b0110_10_10_10, 10'b0010_01_11_10};
        do_reset();
        RUN = 1'b1;
        tick();
        foreach (seq[i]) begin
            INSTR = seq[i];
            IM_ACK = 1'b1;
            tick();
            IM_ACK = 1'b0;
            m_ir = seq[i];
            tick();
            if (i == 0) begin
                m_ill = 1'b1;
                n_chk++;
                if (obs() !== expect_vec(EXEC)) begin
                    n_fail++;
                    $display("FAIL illegal_exec: got %h expected %h", obs(), expect_vec(EXEC));
                end
                tick();
            end
        end
        n_chk++;
        if (obs() !== expect_vec(MEM)) begin
            n_fail++;
            $display("FAIL mid_mem_before_reset: got %h expected %h", obs(), expect_vec(MEM));
        end
        RUN = 1'b0;
        #2 RST = 1'b1;
        #1;
        n_chk++;
        if (obs() !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_mid_mem: got %h expected %h", obs(), 17'd0);
        end
        m_ir = '0;
        m_ill = 1'b0;
        #1 RST = 1'b0;
        tick();
        n_chk++;
        if (obs() !== expect_vec(IDLE)) begin
            n_fail++;
            $display("FAIL after_reset_idle: got %h expected %h", obs(), expect_vec(IDLE));
        end
    endtask

    task automatic test_pause();
        RUN = 1'b1;
        tick();
        INSTR = 10'b0100_00_11_00;
        IM_ACK = 1'b1;
        tick();
        IM_ACK = 1'b0;
        m_ir = INSTR;
        tick();
        n_chk++;
        if (obs() !== expect_vec(EXEC)) begin
            n_fail++;
            $display("FAIL brz_exec: got %h expected %h", obs(), expect_vec(EXEC));
        end
        RUN = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (obs() !== expect_vec(IDLE)) begin
                n_fail++;
                $display("FAIL pause_idle cycle %0d: got %h expected %h", i, obs(), expect_vec(IDLE));
            end
            IM_ACK = 1'b1;
            tick();
        end
        IM_ACK = 1'b0;
        RUN = 1'b1;
        tick();
        n_chk++;
        if (obs() !== expect_vec(FETCH)) begin
            n_fail++;
            $display("FAIL resume_fetch: got %h expected %h", obs(), expect_vec(FETCH));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_program();
        test_timeout();
        test_reset_mid_mem();
        test_pause();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
